dec_scan: RTL and testbench

DEC_SCAN -- requirements
Module: dec_scan

---
 rtl/dec_scan.sv | 137 +++++++++++++
 tb/tb_dec_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan.sv
// -----------------------------------------------------------------------------
// dec_scan
//   Registered N-to-2^N one-hot decoder with an auto-scan mode.
//   In decode mode the output follows `sel` one cycle later. In scan mode the
//   active position holds for DWELL cycles, then advances modulo W. `wrap`
//   pulses when the scan rolls from W-1 to 0. `load` restarts the scan at
//   `sel`.
//
// Parameters
//   N      select width (1..6); output width W = 2**N
//   DWELL  cycles each scan position is held (1..255)
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   e      in   enable; 0 clears the output and freezes the scan position
//   mode   in   0 = registered decode, 1 = auto-scan
//   sel    in   decode select / scan start index (with load)
//   load   in   restart the scan at sel
//   I      out  registered one-hot output
//   idx    out  registered binary index of the active bit
//   valid  out  I holds exactly one set bit
//   wrap   out  one-cycle pulse on scan rollover W-1 -> 0
// -----------------------------------------------------------------------------
module dec_scan #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            e,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    input  logic            load,
    output logic [2**N-1:0] I,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);

    localparam int W  = 2**N;
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        SCAN
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    I_q, I_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enable and mode alone select the target state
    always_comb begin
        state_d = state_q;
        if (!e) begin
            state_d = IDLE;
        end else if (mode) begin
            state_d = SCAN;
        end else begin
            state_d = DECODE;
        end
    end

    // Output / datapath next values, keyed on the state being entered so that
    // the outputs are registered on the same edge as the state change.
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        case (state_d)
            DECODE: begin
                idx_d   = sel;
                valid_d = 1'b1;
            end
            SCAN: begin
                valid_d = 1'b1;
                if (state_q != SCAN) begin
                    idx_d = load ? sel : '0;
                    cnt_d = '0;
                end else if (load) begin
                    // load outranks a same-cycle dwell expiry and never wraps
                    idx_d = sel;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    idx_d  = idx_q + N'(1);
                    cnt_d  = '0;
                    wrap_d = (idx_q == '1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE: output cleared, idx and dwell counter held
            end
        endcase
        I_d = valid_d ? (W'(1) << idx_d) : '0;
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            I_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            I_q     <= I_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign I     = I_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// -----------------------------------------------------------------------------
// tb_dec_scan
//   Checks two dec_scan instances side by side: the default configuration
//   (N=3, DWELL=4) and the smallest corner (N=1, DWELL=1). A behavioural
//   model tracks the active position and how long it has been shown.
// -----------------------------------------------------------------------------
module tb_dec_scan;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int W  = 8;
    localparam int CN = 1;
    localparam int CD = 1;
    localparam int CW = 2;

    logic clk;
    logic rst_n;

    logic          e, mode, load;
    logic [N-1:0]  sel;
    logic [W-1:0]  I;
    logic [N-1:0]  idx;
    logic          valid, wrap;

    logic          ce, cmode, cload;
    logic [CN-1:0] csel;
    logic [CW-1:0] cI;
    logic [CN-1:0] cidx;
    logic          cvalid, cwrap;

    int total = 0;
    int bad   = 0;

    dec_scan #(.N(N), .DWELL(D)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .I     (I),
        .idx   (idx),
        .valid (valid),
        .wrap  (wrap)
    );

    dec_scan #(.N(CN), .DWELL(CD)) u_corner (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (ce),
        .mode  (cmode),
        .sel   (csel),
        .load  (cload),
        .I     (cI),
        .idx   (cidx),
        .valid (cvalid),
        .wrap  (cwrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the position on show, how many cycles it has been shown, and
    // whether the previous cycle was already scanning.
    typedef struct {
        int pos;
        int held;
        bit scan;
        bit valid;
        bit wrap;
    } model_t;

    model_t m, cm;

    function automatic model_t mreset();
        model_t x;
        x.pos = 0; x.held = 0; x.scan = 0; x.valid = 0; x.wrap = 0;
        return x;
    endfunction

    function automatic model_t mstep(model_t x, int w, int dw, bit en, bit md, bit ld, int s);
        x.wrap = 0;
        if (!en) begin
            x.valid = 0;
            x.scan  = 0;
        end else if (!md) begin
            x.pos   = s;
            x.valid = 1;
            x.scan  = 0;
        end else if (!x.scan || ld) begin
            x.pos   = ld ? s : 0;
            x.held  = 1;
            x.scan  = 1;
            x.valid = 1;
        end else if (x.held == dw) begin
            x.wrap = (x.pos == w - 1);
            x.pos  = (x.pos + 1) % w;
            x.held = 1;
        end else begin
            x.held++;
        end
        return x;
    endfunction

    function automatic logic [63:0] exp_i(model_t x);
        return x.valid ? (64'd1 << x.pos) : 64'd0;
    endfunction

    task automatic compare_all();
        check("I",        I,       exp_i(m));
        check("idx",      idx,     m.pos);
        check("valid",    valid,   m.valid);
        check("wrap",     wrap,    m.wrap);
        check("onehot",   $countones(I) <= 1, 1);
        check("c_I",      cI,      exp_i(cm));
        check("c_idx",    cidx,    cm.pos);
        check("c_valid",  cvalid,  cm.valid);
        check("c_wrap",   cwrap,   cm.wrap);
        check("c_onehot", $countones(cI) <= 1, 1);
    endtask

    // One clock: model advances at the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m  = mreset();
            cm = mreset();
        end else begin
            m  = mstep(m,  W,  D,  e,  mode,  load,  int'(sel));
            cm = mstep(cm, CW, CD, ce, cmode, cload, int'(csel));
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int wrap_at;
        int n;
        logic [CW-1:0] prev;

        e = 0; mode = 0; load = 0; sel = '0;
        ce = 1; cmode = 1; cload = 0; csel = '0;
        rst_n = 1'b0;
        m  = mreset();
        cm = mreset();

        // reset state
        repeat (2) tick();
        rst_n = 1'b1;

        // decode sweep
        e = 1; mode = 0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            check("dec_sweep", I, 64'd1 << s);
        end

        // disable then re-enable
        e = 0; sel = 3'($urandom);
        tick();
        check("dis_I", I, 0);
        e = 1; sel = 3'd5;
        tick();
        check("reen_I", I, 64'h20);

        // scan from IDLE, wrap 32 cycles after entry
        e = 0; tick();
        e = 1; mode = 1;
        wrap_at = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (wrap && wrap_at < 0) wrap_at = c;
        end
        check("wrap_cycle", wrap_at, 32);

        // load on the dwell-expiry cycle at idx 2
        n = 0;
        while (!(m.pos == 2 && m.held == D) && n < 100) begin tick(); n++; end
        check("reach_idx2", n < 100, 1);
        load = 1; sel = 3'd6;
        tick();
        load = 0;
        check("load_idx", idx, 6);
        check("load_wrap", wrap, 0);
        repeat (3) tick();
        check("load_dwell_hold", idx, 6);
        tick();
        check("load_dwell_adv", idx, 7);

        // load sel=0 at idx 7 gives no wrap
        load = 1; sel = 3'd0;
        tick();
        load = 0;
        check("load0_idx", idx, 0);
        check("load0_wrap", wrap, 0);

        // async reset mid-scan at idx 4
        n = 0;
        while (m.pos != 4 && n < 100) begin tick(); n++; end
        check("reach_idx4", n < 100, 1);
        #2 rst_n = 1'b0;
        #1;
        m  = mreset();
        cm = mreset();
        check("arst_I", I, 0);
        check("arst_idx", idx, 0);
        check("arst_valid", valid, 0);
        check("arst_wrap", wrap, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_idx", idx, 0);
        check("restart_valid", valid, 1);

        // corner: alternates every cycle
        ce = 1; cmode = 1; cload = 0;
        tick();
        prev = cI;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("c_alt", cI, prev ^ 2'b11);
            prev = cI;
        end

        // randomized mix
        for (int c = 0; c < 800; c++) begin
            e     = ($urandom % 8) != 0;
            mode  = ($urandom % 4) != 0;
            load  = ($urandom % 10) == 0;
            sel   = 3'($urandom);
            ce    = ($urandom % 8) != 0;
            cmode = ($urandom % 4) != 0;
            cload = ($urandom % 10) == 0;
            csel  = 1'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
